int8_add_sub: RTL and testbench
===============================

INT8_ADD_SUB -- requirements
Module: int8_add_sub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-002 and REQ-003.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 a  input  8  operand A, unsigned or two's-complement.
REQ-005 b  input  8  operand B, unsigned or two's-complement.
REQ-006 mux  input  1  operation select: 0 = add (A+B), 1 = subtract (A-B).
REQ-007 in_valid  input  1  operands and mux are valid this cycle.
REQ-008 sum  output  8  registered result, low 8 bits.
REQ-009 cout  output  1  registered carry out of bit 7.
REQ-010 out_valid  output  1  sum and cout hold a new result this cycle.
REQ-011 zero, neg, ovf  output  1 each  registered flags; present only when INT8_ADD_SUB_FLAGS_EN is defined (REQ-027).

Function
REQ-012 Add: {cout,sum} SHALL equal A + B as a 9-bit unsigned sum.
REQ-013 Subtract: {cout,sum} SHALL equal A + ~B + 1 as a 9-bit sum, computed by the same single 8-bit adder with B inverted and carry-in = mux.
REQ-014 Subtract carry convention: cout=1 means no borrow (A >= B unsigned); cout=0 means borrow.
REQ-015 Latency SHALL be exactly one clock: operands sampled on a rising edge with in_valid=1 SHALL appear on sum/cout after that edge, with out_valid=1.
REQ-016 On an edge where in_valid=0, sum, cout and the flags SHALL hold their previous values, and out_valid SHALL be 0.
REQ-017 out_valid SHALL be a one-cycle pulse per accepted operation; back-to-back in_valid SHALL give back-to-back results with no bubbles.
REQ-018 mux MAY change every cycle; each result SHALL use the mux value sampled with its own operands.
REQ-019 8-bit wrap-around SHALL be silent: results modulo 256, with overflow visible only through cout (and ovf when enabled).
REQ-020 No state machine; the only state is the output register stage.

Reset
REQ-021 While rst=1, sum SHALL be 0x00, cout 0, out_valid 0, and zero/neg/ovf 0, independent of clk.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; no out_valid pulse SHALL follow it.
REQ-023 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Configuration
REQ-024 Macro INT8_ADD_SUB_FLAGS_EN SHALL control the status flags.
REQ-025 With the macro defined: zero = (result == 0x00); neg = result bit 7; ovf = signed two's-complement overflow of the selected operation.
REQ-026 With the macro defined, the flags SHALL be registered alongside sum, share its latency and hold rules, and clear on reset.
REQ-027 Without the macro: the zero/neg/ovf ports and their logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Add: a=0x43, b=0x35, mux=0, in_valid=1 -> next cycle sum=0x78, cout=0, out_valid=1 (flags: zero=0, neg=0, ovf=0).
REQ-029 Add wrap: a=0xFF, b=0x0F, mux=0 -> sum=0x0E, cout=1 (ovf=0).
REQ-030 Subtract: a=0xFF, b=0x0F, mux=1 -> sum=0xF0, cout=1 (neg=1, ovf=0).
REQ-031 Subtract zero/borrow: a=0x00, b=0x00, mux=1 -> sum=0x00, cout=1, zero=1; then a=0x00, b=0x01, mux=1 -> sum=0xFF, cout=0.
REQ-032 Signed overflow: a=0x7F, b=0x01, mux=0 -> sum=0x80, ovf=1; a=0x80, b=0x01, mux=1 -> sum=0x7F, ovf=1.
REQ-033 Hold/reset: in_valid=0 for 3 cycles -> outputs unchanged and out_valid=0; assert rst between edges -> all outputs 0 immediately, with no pending out_valid after release.

Source files
------------

// File: rtl/int8_add_sub_if.sv
// Operand/result bundle for int8_add_sub.
// The zero/neg/ovf flag signals exist only when INT8_ADD_SUB_FLAGS_EN is defined.
interface int8_add_sub_if;
   logic [7:0] a;
   logic [7:0] b;
   logic       mux;
   logic       in_valid;
   logic [7:0] sum;
   logic       cout;
   logic       out_valid;
`ifdef INT8_ADD_SUB_FLAGS_EN
   logic       zero;
   logic       neg;
   logic       ovf;

   modport master (
      output a, b, mux, in_valid,
      input  sum, cout, out_valid, zero, neg, ovf
   );
   modport slave (
      input  a, b, mux, in_valid,
      output sum, cout, out_valid, zero, neg, ovf
   );
`else
   modport master (
      output a, b, mux, in_valid,
      input  sum, cout, out_valid
   );
   modport slave (
      input  a, b, mux, in_valid,
      output sum, cout, out_valid
   );
`endif
endinterface

// File: rtl/int8_add_sub.sv
// Registered 8-bit add/subtract with one-cycle latency; subtract uses the same adder with B inverted, carry-in = mux.
// Optional zero/neg/ovf status flags are built when INT8_ADD_SUB_FLAGS_EN is defined.
module int8_add_sub (
   input  logic          clk,
   input  logic          rst,
   int8_add_sub_if.slave bus
);

   logic [7:0] b_eff;
   logic [8:0] carry;
   logic [7:0] sum_next;

   logic [7:0] sum_reg;
   logic       cout_reg;
   logic       valid_reg;

   // Ripple-carry adder; carry[8] is the carry out of bit 7.
   assign carry[0] = bus.mux;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bit
         assign b_eff[gi]     = bus.b[gi] ^ bus.mux;
         assign sum_next[gi]  = bus.a[gi] ^ b_eff[gi] ^ carry[gi];
         assign carry[gi + 1] = (bus.a[gi] & b_eff[gi]) |
                                (carry[gi] & (bus.a[gi] ^ b_eff[gi]));
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_reg   <= 8'h00;
         cout_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            sum_reg  <= sum_next;
            cout_reg <= carry[8];
         end
      end
   end

   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;
   assign bus.out_valid = valid_reg;

`ifdef INT8_ADD_SUB_FLAGS_EN
   logic zero_reg;
   logic neg_reg;
   logic ovf_reg;
   logic ovf_next;

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf_next = carry[8] ^ carry[7];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero_reg <= 1'b0;
         neg_reg  <= 1'b0;
         ovf_reg  <= 1'b0;
      end else if (bus.in_valid) begin
         zero_reg <= (sum_next == 8'h00);
         neg_reg  <= sum_next[7];
         ovf_reg  <= ovf_next;
      end
   end

   assign bus.zero = zero_reg;
   assign bus.neg  = neg_reg;
   assign bus.ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_int8_add_sub.sv
// Directed-vector bench for int8_add_sub: literal expectations per vector plus a per-cycle arithmetic model check.
// Flag checks are compiled in when INT8_ADD_SUB_FLAGS_EN is defined.
module tb_int8_add_sub;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int tests = 0;
   int fails = 0;

   int8_add_sub_if bus ();

   int8_add_sub dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic model: plain integer add/subtract, not a gate-level adder.
   logic [7:0] m_sum;
   logic       m_cout, m_valid, m_zero, m_neg, m_ovf;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_sum   <= 8'h00;
         m_cout  <= 1'b0;
         m_valid <= 1'b0;
         m_zero  <= 1'b0;
         m_neg   <= 1'b0;
         m_ovf   <= 1'b0;
      end else begin
         m_valid <= bus.in_valid;
         if (bus.in_valid) begin
            int ua, ub, sa, sb, ur, sr;
            ua = int'(bus.a);
            ub = int'(bus.b);
            sa = (ua > 127) ? ua - 256 : ua;
            sb = (ub > 127) ? ub - 256 : ub;
            if (bus.mux) begin
               ur = ua - ub;
               sr = sa - sb;
               m_cout <= (ua >= ub);
            end else begin
               ur = ua + ub;
               sr = sa + sb;
               m_cout <= (ur > 255);
            end
            m_sum  <= 8'((ur + 256) % 256);
            m_zero <= (((ur + 256) % 256) == 0);
            m_neg  <= (((ur + 256) % 256) >= 128);
            m_ovf  <= (sr > 127) || (sr < -128);
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("cyc_sum", 32'(bus.sum), 32'(m_sum));
      check("cyc_cout", 32'(bus.cout), 32'(m_cout));
`ifdef INT8_ADD_SUB_FLAGS_EN
      check("cyc_zero", 32'(bus.zero), 32'(m_zero));
      check("cyc_neg", 32'(bus.neg), 32'(m_neg));
      check("cyc_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
   end

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       mux;
      logic [7:0] sum;
      logic       cout;
      logic       zero;
      logic       neg;
      logic       ovf;
   } vec_t;

   vec_t vecs[9];

   task automatic check_literal(input string tag, input vec_t v);
      check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_sum"}, 32'(bus.sum), 32'(v.sum));
      check({tag, "_cout"}, 32'(bus.cout), 32'(v.cout));
      check({tag, "_model_sum"}, 32'(m_sum), 32'(v.sum));
`ifdef INT8_ADD_SUB_FLAGS_EN
      check({tag, "_zero"}, 32'(bus.zero), 32'(v.zero));
      check({tag, "_neg"}, 32'(bus.neg), 32'(v.neg));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(v.ovf));
`endif
   endtask

   initial begin
      //           a      b      mux   sum    cout  zero  neg   ovf
      vecs[0] = '{8'h43, 8'h35, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h0F, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[6] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[8] = '{8'h50, 8'hB0, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b1, 1'b1};

      bus.a        = 8'h00;
      bus.b        = 8'h00;
      bus.mux      = 1'b0;
      bus.in_valid = 1'b0;

      #1;
      check("reset_sum", 32'(bus.sum), 32'h00);
      check("reset_cout", 32'(bus.cout), 32'd0);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);

      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Back-to-back vectors with mux changing between them.
      for (int i = 0; i < 9; i++) begin
         bus.a        = vecs[i].a;
         bus.b        = vecs[i].b;
         bus.mux      = vecs[i].mux;
         bus.in_valid = 1'b1;
         @(posedge clk);
         #1;
         $display("[TB] vec %0d: a=%02h b=%02h mux=%0d -> sum=%02h cout=%0d", i,
                  vecs[i].a, vecs[i].b, vecs[i].mux, bus.sum, bus.cout);
         check_literal($sformatf("vec%0d", i), vecs[i]);
      end

      // Idle cycles with changing operands must leave the result untouched.
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.a   = 8'(i * 37 + 5);
         bus.b   = 8'(i * 11 + 3);
         bus.mux = 1'(i);
         @(posedge clk);
         #1;
         $display("[TB] hold %0d: sum=%02h out_valid=%0d", i, bus.sum, bus.out_valid);
         check("hold_out_valid", 32'(bus.out_valid), 32'd0);
         check("hold_sum", 32'(bus.sum), 32'hA0);
         check("hold_cout", 32'(bus.cout), 32'd0);
      end

      // Capture a result, then reset between edges with another op pending.
      bus.a        = 8'h43;
      bus.b        = 8'h35;
      bus.mux      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
      bus.a = 8'h12;
      bus.b = 8'h34;
      #2;
      rst = 1'b1;
      #1;
      $display("[TB] async reset: sum=%02h cout=%0d out_valid=%0d", bus.sum, bus.cout, bus.out_valid);
      check("async_rst_sum", 32'(bus.sum), 32'h00);
      check("async_rst_cout", 32'(bus.cout), 32'd0);
      check("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
`ifdef INT8_ADD_SUB_FLAGS_EN
      check("async_rst_flags", 32'({bus.zero, bus.neg, bus.ovf}), 32'd0);
`endif
      bus.in_valid = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_reset_no_pulse", 32'(bus.out_valid), 32'd0);
      check("post_reset_sum", 32'(bus.sum), 32'h00);

      // First valid edge after reset is accepted normally.
      bus.a        = 8'hFF;
      bus.b        = 8'h0F;
      bus.mux      = 1'b1;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      $display("[TB] post-reset op: sum=%02h cout=%0d", bus.sum, bus.cout);
      check_literal("post_reset_op", vecs[2]);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("pulse_end", 32'(bus.out_valid), 32'd0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
